// File: rtl/rom_seq_reader.sv
// rom_seq_reader: upstream master for rom_ctrl. Walks a contiguous ROM address
// range, captures the registered read data into a small FIFO and presents it as
// a valid/ready stream. Reads are only issued when the FIFO is guaranteed to
// have room for them, so backpressure never drops a ROM word.
//
// Stream handshake: a word transfers on every clk edge where out_valid and
// out_ready are both 1; once out_valid is 1, out_data/out_last stay stable
// until that transfer happens, and out_valid never depends on out_ready.
module rom_seq_reader #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   length,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W:0]   len_clamped;
   logic              rom_last;       // tag travelling with the issued read
   logic              inflight;
   logic              inflight_last;

   logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
   logic              last_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  fifo_count;

   logic [CNT_W:0]    occupancy;
   logic              credit_ok;
   logic              issue;
   logic              push;
   logic              pop;

   // Credit check: words already buffered plus every read that will still land
   // (in flight now, or being issued this cycle) must leave a free slot.
   always_comb begin
      len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
      occupancy   = {1'b0, fifo_count}
                  + {{CNT_W{1'b0}}, inflight}
                  + {{CNT_W{1'b0}}, rom_en};
      credit_ok   = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
      issue       = (state == S_RUN) && (remaining != '0) && credit_ok;
      push        = inflight;
      pop         = out_valid && out_ready;
   end

   // Burst sequencer: IDLE issues the first read directly so rom_en follows start by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr      <= '0;
         remaining <= '0;
         rom_en    <= 1'b0;
         rom_addr  <= '0;
         rom_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         rom_en   <= 1'b0;
         rom_last <= 1'b0;
         done     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (len_clamped == '0) begin
                     done <= 1'b1;
                  end else begin
                     rom_en    <= 1'b1;
                     rom_addr  <= start_addr;
                     rom_last  <= (len_clamped == (ADDR_W + 1)'(1));
                     addr      <= start_addr + ADDR_W'(1);
                     remaining <= len_clamped - (ADDR_W + 1)'(1);
                     state     <= (len_clamped == (ADDR_W + 1)'(1)) ? S_DRAIN : S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (issue) begin
                  rom_en    <= 1'b1;
                  rom_addr  <= addr;
                  rom_last  <= (remaining == (ADDR_W + 1)'(1));
                  addr      <= addr + ADDR_W'(1);
                  remaining <= remaining - (ADDR_W + 1)'(1);
                  if (remaining == (ADDR_W + 1)'(1)) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if ((fifo_count == '0) && !inflight && !rom_en) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Read-data capture and output FIFO; a read issued last cycle lands now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_mem[i] <= '0;
            last_mem[i] <= 1'b0;
         end
      end else begin
         inflight      <= rom_en;
         inflight_last <= rom_last;
         if (push) begin
            data_mem[wr_ptr] <= rom_dout;
            last_mem[wr_ptr] <= inflight_last;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Stream outputs come straight from the FIFO head; zero when empty.
   always_comb begin
      out_valid = (fifo_count != '0);
      out_data  = out_valid ? data_mem[rd_ptr] : '0;
      out_last  = out_valid ? last_mem[rd_ptr] : 1'b0;
      busy      = (state != S_IDLE);
      dbg_state = state;
   end

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed bench for rom_seq_reader with a 1-cycle ROM model (mem[a] = a ^ 8'h5A).
module tb_rom_seq_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] length;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_dout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  rom_seq_reader #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset / ROM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_dout <= rom_en ? (rom_addr ^ 8'h5A) : 8'h00;

  // ---------------- monitor (negedge sampling) ----------------
  logic [8:0] got_q[$];
  int         acc_cyc_q[$];
  logic [7:0] addr_q[$];
  int         en_cyc_q[$];
  int         done_cnt = 0;
  int         busy_cnt = 0;
  int         done_busy_bad = 0;
  int         done_after_busy = 0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_en) begin
        addr_q.push_back(rom_addr);
        en_cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_data});
        acc_cyc_q.push_back(cyc);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (busy) done_busy_bad++;
        if (busy_prev) done_after_busy++;
      end
      busy_prev = busy;
    end else begin
      busy_prev = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int got_rd   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_words(input string tag, input int n);
    logic [8:0] e;
    check({tag, "_count"}, 32'(got_q.size() - got_rd), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (got_rd < got_q.size()) begin
        check($sformatf("%s_w%0d", tag, i), 32'(got_q[got_rd]), 32'(e));
        got_rd++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] sa, input logic [8:0] len, output int t);
    tick(1);
    start      = 1'b1;
    start_addr = sa;
    length     = len;
    t          = cyc;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == budget) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    tick(2);
  endtask

  // ---------------- directed tests ----------------
  int t0, en0, acc0, d0, b0, da0;
  int i0;

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = 8'h00; length = 9'd0; out_ready = 1'b1;
    tick(3);
    check("reset_outputs", {rom_en, rom_addr, out_valid, out_data, out_last, busy, done},
          32'd0);
    rst_n = 1'b1;
    tick(2);

    // T1: 0x10, 4 words, ready held high
    en0 = en_cyc_q.size(); acc0 = acc_cyc_q.size(); d0 = done_cnt; da0 = done_after_busy;
    start_burst(8'h10, 9'd4, t0);
    wait_done("t1", 40);
    exp_q.push_back({1'b0, 8'h4A}); exp_q.push_back({1'b0, 8'h4B});
    exp_q.push_back({1'b0, 8'h48}); exp_q.push_back({1'b1, 8'h49});
    compare_words("t1", 4);
    check("t1_first_en_latency", 32'(en_cyc_q[en0] - t0), 32'd1);
    check("t1_first_valid_latency", 32'(acc_cyc_q[acc0] - en_cyc_q[en0]), 32'd2);
    for (int k = 1; k < 4; k++)
      check($sformatf("t1_back_to_back%0d", k), 32'(acc_cyc_q[acc0+k] - acc_cyc_q[acc0+k-1]), 32'd1);
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_done_after_busy", 32'(done_after_busy - da0), 32'd1);
    check("t1_busy_clear_at_done", 32'(done_busy_bad), 32'd0);

    // T2: address wrap FE -> 01
    en0 = addr_q.size();
    start_burst(8'hFE, 9'd4, t0);
    wait_done("t2", 40);
    check("t2_addr0", 32'(addr_q[en0]),   32'h0FE);
    check("t2_addr1", 32'(addr_q[en0+1]), 32'h0FF);
    check("t2_addr2", 32'(addr_q[en0+2]), 32'h000);
    check("t2_addr3", 32'(addr_q[en0+3]), 32'h001);
    exp_q.push_back({1'b0, 8'hA4}); exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h5A}); exp_q.push_back({1'b1, 8'h5B});
    compare_words("t2", 4);

    // T3: 16 words from 0x20 with 20 cycles of backpressure
    out_ready = 1'b0;
    en0 = addr_q.size();
    start_burst(8'h20, 9'd16, t0);
    tick(20);
    check("t3_en_before_release", 32'(addr_q.size() - en0), 32'd4);
    check("t3_head_held", {out_valid, out_data}, {1'b1, 8'h7A});
    out_ready = 1'b1;
    wait_done("t3", 100);
    check("t3_en_total", 32'(addr_q.size() - en0), 32'd16);
    for (int k = 0; k < 16; k++) exp_q.push_back({(k == 15), 8'(8'h20 + k) ^ 8'h5A});
    compare_words("t3", 16);

    // T4: empty burst
    en0 = addr_q.size(); d0 = done_cnt; b0 = busy_cnt;
    start_burst(8'h33, 9'd0, t0);
    wait_done("t4", 10);
    check("t4_no_rom_en", 32'(addr_q.size() - en0), 32'd0);
    check("t4_done_one_cycle", 32'(done_cnt - d0), 32'd1);
    check("t4_busy_stays_low", 32'(busy_cnt - b0), 32'd0);
    check("t4_no_words", 32'(got_q.size() - got_rd), 32'd0);

    // T5: start re-pulsed during RUN is ignored
    en0 = addr_q.size(); d0 = done_cnt;
    start_burst(8'h30, 9'd8, t0);
    tick(1);
    start = 1'b1; start_addr = 8'h80; length = 9'd5;
    tick(1);
    start = 1'b0;
    wait_done("t5", 60);
    check("t5_en_total", 32'(addr_q.size() - en0), 32'd8);
    check("t5_last_addr", 32'(addr_q[addr_q.size()-1]), 32'h037);
    check("t5_done_once", 32'(done_cnt - d0), 32'd1);
    for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), 8'(8'h30 + k) ^ 8'h5A});
    compare_words("t5", 8);

    // T6: reset after 3 words of a 16-word burst, then a clean burst
    start_burst(8'h40, 9'd16, t0);
    for (i0 = 0; i0 < 50; i0++) begin
      @(negedge clk);
      if (got_q.size() - got_rd >= 3) break;
    end
    if (i0 == 50) check("t6_three_words_timeout", 32'd0, 32'd1);
    #1;
    rst_n = 1'b0;
    d0 = done_cnt;
    #1;
    check("t6_reset_outputs", {rom_en, rom_addr, out_valid, out_data, out_last, busy, done},
          32'd0);
    tick(2);
    got_rd = got_q.size();
    rst_n = 1'b1;
    tick(3);
    check("t6_no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    start_burst(8'h50, 9'd2, t0);
    wait_done("t6", 30);
    exp_q.push_back({1'b0, 8'h0A}); exp_q.push_back({1'b1, 8'h0B});
    compare_words("t6", 2);

    // T7: length above 2**ADDR_W clamps to 256 words
    en0 = addr_q.size(); acc0 = got_q.size();
    start_burst(8'h00, 9'h12C, t0);
    wait_done("t7", 400);
    check("t7_en_clamped", 32'(addr_q.size() - en0), 32'd256);
    check("t7_words_clamped", 32'(got_q.size() - acc0), 32'd256);
    check("t7_final_word", 32'(got_q[got_q.size()-1]), {23'd0, 1'b1, 8'hA5});
    got_rd = got_q.size();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
